// File: rtl/router_pkg.sv
// Shared router types and constants for the output-port serializers.
package router_pkg;

  localparam int ROUTER_WORD_W = 32;
  localparam int NUM_PORTS     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/port_tx_serializer.sv
// Output-port serializer: pops one FIFO word, sends it as one serial frame.
// Define PORT_TX_PARITY_EN to append an even-parity bit to every frame.
module port_tx_serializer
  import router_pkg::*;
#(
  parameter int WORD_W    = ROUTER_WORD_W,
  parameter int MIN_GAP   = 1,
  parameter int LSB_FIRST = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] payload,
  input  logic              rdy,
  input  logic              stall,
  output logic              pop,
  output logic              dout,
  output logic              valido_n,
  output logic              frameo_n
);

  localparam int CW = $clog2(WORD_W + 1);
`ifdef PORT_TX_PARITY_EN
  localparam int LAST = WORD_W;
`else
  localparam int LAST = WORD_W - 1;
`endif
  localparam logic [CW-1:0] LAST_C   = CW'(LAST);
  localparam logic [3:0]    GAP_LAST = 4'(MIN_GAP - 1);

  tx_state_t         state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              dout_q, dout_d;
  logic              valn_q, valn_d;
  logic              frn_q, frn_d;
`ifdef PORT_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic              is_last;
  logic              cur_bit;
  logic              first_bit;
  logic [WORD_W-1:0] load_shift;
  logic [WORD_W-1:0] next_shift;

  assign pop      = (state_q == IDLE) & rdy & ~stall & ~reset;
  assign is_last  = (bit_cnt_q == LAST_C);
  assign dout     = dout_q;
  assign valido_n = valn_q;
  assign frameo_n = frn_q;

  // Bit 0 leaves on the pop edge, so the register holds the remainder.
  assign first_bit  = (LSB_FIRST != 0) ? payload[0] : payload[WORD_W-1];
  assign load_shift = (LSB_FIRST != 0) ? (payload >> 1) : (payload << 1);
  assign next_shift = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);

`ifdef PORT_TX_PARITY_EN
  assign cur_bit = (bit_cnt_q == CW'(WORD_W)) ? par_q :
                   ((LSB_FIRST != 0) ? shift_q[0] : shift_q[WORD_W-1]);
`else
  assign cur_bit = (LSB_FIRST != 0) ? shift_q[0] : shift_q[WORD_W-1];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      shift_q   <= '0;
      dout_q    <= 1'b0;
      valn_q    <= 1'b1;
      frn_q     <= 1'b1;
`ifdef PORT_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      shift_q   <= shift_d;
      dout_q    <= dout_d;
      valn_q    <= valn_d;
      frn_q     <= frn_d;
`ifdef PORT_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (pop) state_d = SEND;
      SEND: begin
        if (!stall && is_last)
          state_d = (MIN_GAP > 0) ? GAP : IDLE;
      end
      GAP:  if (gap_cnt_q == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    shift_d   = shift_q;
    dout_d    = 1'b0;
    valn_d    = 1'b1;
    frn_d     = 1'b1;
`ifdef PORT_TX_PARITY_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d   = load_shift;
          dout_d    = first_bit;
          valn_d    = 1'b0;
          frn_d     = 1'b0;
          bit_cnt_d = CW'(1);
`ifdef PORT_TX_PARITY_EN
          par_d     = ^payload;
`endif
        end
      end
      SEND: begin
        if (stall) begin
          frn_d = 1'b0;
        end else begin
          dout_d    = cur_bit;
          valn_d    = 1'b0;
          frn_d     = is_last;
          shift_d   = next_shift;
          bit_cnt_d = is_last ? '0 : bit_cnt_q + CW'(1);
        end
      end
      GAP: begin
        gap_cnt_d = (gap_cnt_q == GAP_LAST) ? '0 : gap_cnt_q + 4'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_port_tx_serializer.sv
// Bench for port_tx_serializer: scoreboard of expected bits plus directed steps.
// Honours PORT_TX_PARITY_EN in the same way as the design.
module tb_port_tx_serializer;
  import router_pkg::*;

  localparam int W       = ROUTER_WORD_W;
  localparam int MIN_GAP = 1;
`ifdef PORT_TX_PARITY_EN
  localparam int FB = W + 1;
`else
  localparam int FB = W;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         rdy = 1'b0;
  logic         stall = 1'b0;
  logic [W-1:0] payload = '0;
  logic         pop, dout, valido_n, frameo_n;

  always #5 clock = ~clock;

  port_tx_serializer #(
    .WORD_W(W),
    .MIN_GAP(MIN_GAP),
    .LSB_FIRST(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .payload(payload),
    .rdy(rdy),
    .stall(stall),
    .pop(pop),
    .dout(dout),
    .valido_n(valido_n),
    .frameo_n(frameo_n)
  );

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int failed = 0;
  int pop_cnt = 0;
  int frames_done = 0;
  int valid_cnt = 0;
  int span = 0;
  int stalls = 0;
  int idle_run = 0;
  int last_valid = 0;
  int last_span = 0;
  int last_stalls = 0;
  int last_gap = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_pops(input int n, input string tag);
    int k = 0;
    while (pop_cnt < n && k < 200) begin
      tick();
      k++;
    end
    chk(tag, pop_cnt, n);
  endtask

  task automatic wait_frames(input int n, input string tag);
    int k = 0;
    while (frames_done < n && k < 200) begin
      tick();
      k++;
    end
    chk(tag, frames_done, n);
  endtask

  // Pin monitor: compares each valid bit against the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      valid_cnt = 0;
      span = 0;
      stalls = 0;
      idle_run = 0;
    end else begin
      if (!valido_n || !frameo_n) begin
        if (span == 0) last_gap = idle_run;
        idle_run = 0;
        span++;
        if (!valido_n) begin
          valid_cnt++;
          if (sb.size() == 0) begin
            tests++;
            failed++;
            $error("FAIL sb_empty: observed valid bit expected none");
          end else begin
            e = sb.pop_front();
            chk("dout", dout, e.b);
            chk("frameo_n", frameo_n, e.last);
            if (e.last) begin
              last_valid  = valid_cnt;
              last_span   = span;
              last_stalls = stalls;
              frames_done++;
              valid_cnt = 0;
              span = 0;
              stalls = 0;
            end
          end
        end else begin
          stalls++;
          chk("stall_dout", dout, 0);
        end
      end else begin
        idle_run++;
      end
      if (pop === 1'b1) begin
        pop_cnt++;
        for (int i = 0; i < W; i++) begin
          e.b    = payload[i];
          e.last = (FB == W) && (i == W - 1);
          sb.push_back(e);
        end
`ifdef PORT_TX_PARITY_EN
        e.b    = ^payload;
        e.last = 1'b1;
        sb.push_back(e);
`endif
      end
    end
  end

  initial begin
    // reset holds everything idle even with rdy high
    reset   = 1'b1;
    rdy     = 1'b1;
    payload = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk("rst_pop", pop, 0);
      chk("rst_dout", dout, 0);
      chk("rst_valido_n", valido_n, 1);
      chk("rst_frameo_n", frameo_n, 1);
    end
    tick();
    reset = 1'b0;
    rdy   = 1'b0;
    tick();

    // single word, one-cycle rdy pulse
    payload = 32'h8000_0001;
    rdy     = 1'b1;
    @(negedge clock);
    chk("t2_pop", pop, 1);
    tick();
    rdy = 1'b0;
    @(negedge clock);
    chk("t2_first_bit", dout, 1);
    chk("t2_first_valid", valido_n, 0);
    wait_frames(1, "t2_frames");
    chk("t2_pops", pop_cnt, 1);
    chk("t2_valid", last_valid, FB);
    chk("t2_span", last_span, FB);

    // back-to-back frames with rdy held high
    payload = 32'hA5A5_A5A5;
    rdy     = 1'b1;
    wait_pops(2, "t3_pop_a");
    payload = 32'h0F0F_0F0F;
    wait_pops(3, "t3_pop_b");
    rdy = 1'b0;
    wait_frames(3, "t3_frames");
    chk("t3_gap", last_gap, MIN_GAP);
    chk("t3_valid", last_valid, FB);
    chk("t3_pops", pop_cnt, 3);

    // three stall cycles when bit 10 is due
    payload = 32'h0000_0400;
    rdy     = 1'b1;
    wait_pops(4, "t4_pop");
    rdy = 1'b0;
    repeat (9) tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) stall = 1'b0;
      @(negedge clock);
      chk("t4_stall_valido_n", valido_n, 1);
      chk("t4_stall_frameo_n", frameo_n, 0);
    end
    @(negedge clock);
    chk("t4_bit10", dout, 1);
    chk("t4_bit10_valid", valido_n, 0);
    wait_frames(4, "t4_frames");
    chk("t4_stalls", last_stalls, 3);
    chk("t4_span", last_span, FB + 3);
    chk("t4_valid", last_valid, FB);

    // reset while bit 5 is on the pins
    payload = 32'hFFFF_FFFF;
    rdy     = 1'b1;
    wait_pops(5, "t5_pop");
    repeat (5) tick();
    reset = 1'b1;
    @(negedge clock);
    chk("t5_bit5", dout, 1);
    chk("t5_bit5_valid", valido_n, 0);
    tick();
    @(negedge clock);
    chk("t5_idle_dout", dout, 0);
    chk("t5_idle_valido_n", valido_n, 1);
    chk("t5_idle_frameo_n", frameo_n, 1);
    chk("t5_idle_pop", pop, 0);
    tick();
    reset = 1'b0;
    rdy   = 1'b0;
    repeat (3) tick();
    chk("t5_no_repop", pop_cnt, 5);
    chk("t5_no_frame", frames_done, 4);
    payload = 32'h1357_9BDF;
    rdy     = 1'b1;
    wait_pops(6, "t5_pop_after");
    rdy = 1'b0;
    wait_frames(5, "t5_frames");
    chk("t5_valid", last_valid, FB);

    // low-weight word: parity bit appended when enabled
    payload = 32'h0000_0007;
    rdy     = 1'b1;
    wait_pops(7, "t6_pop");
    rdy = 1'b0;
    wait_frames(6, "t6_frames");
    chk("t6_valid", last_valid, FB);
    chk("t6_span", last_span, FB);

    repeat (4) tick();
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
